// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue/response sequencer between pipeline and MDU; define MDU_ISSUE_WATCHDOG_EN to add a WAIT watchdog
module mdu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        int_req,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_result,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready,
  output logic        stall,
  output logic        err
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
  logic        accept, op_long, op_read, op_known, wd_trip;
  assign op_known = (op_q != 4'd0) && (op_q <= 4'd12);
  assign op_read  = (op_q == 4'd5) || (op_q == 4'd6);
  assign op_long  = op_known && !op_read && (op_q != 4'd7) && (op_q != 4'd8);
  assign accept   = req_valid && req_ready;
`ifdef MDU_ISSUE_WATCHDOG_EN
  logic [4:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  // watchdog: count WAIT cycles, trip when the 16th still sees busy
  always_comb begin
    cnt_d   = (state_q == WAIT) ? cnt_q + 5'd1 : 5'd0;
    wd_trip = (state_q == WAIT) && mdu_busy && (cnt_d == 5'd16);
    err_d   = err_q || wd_trip;
  end
  // watchdog registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 5'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif
  // state and captured request/response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 4'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      rsp_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  // next state: an interrupt in ISSUE drops the op; unknown/move-to ops finish in one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = int_req ? IDLE : op_long ? WAIT : op_read ? RESP : IDLE;
      WAIT:    state_d = (!mdu_busy || wd_trip) ? IDLE : WAIT;
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  // capture operands on accept and the read result at the ISSUE edge
  always_comb begin
    op_d       = accept ? req_op : op_q;
    a_d        = accept ? req_a : a_q;
    b_d        = accept ? req_b : b_q;
    rsp_data_d = (state_q == ISSUE && !int_req && op_read) ? mdu_result : rsp_data_q;
  end
  // outputs: mdu_op is only non-zero for a legal op in an uninterrupted ISSUE cycle
  always_comb begin
    req_ready = (state_q == IDLE) && !mdu_busy;
    stall     = req_valid && !req_ready;
    mdu_op    = (state_q == ISSUE && !int_req && op_known) ? op_q : 4'd0;
    mdu_a     = a_q;
    mdu_b     = b_q;
    rsp_valid = (state_q == RESP);
    rsp_data  = rsp_data_q;
  end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: directed bench for mdu_issue_ctrl with a small behavioural MDU
module tb_mdu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, int_req, mdu_busy, rsp_valid, rsp_ready, stall, err;
  logic [3:0]  req_op, mdu_op;
  logic [31:0] req_a, req_b, mdu_a, mdu_b, mdu_result, rsp_data;
  logic [31:0] hi = 32'd0, lo = 32'd0;
  logic [3:0]  bcnt = 4'd0;
  logic        stuck;
  int          n_chk = 0, n_pass = 0, n, nop, nrsp;
  mdu_issue_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .int_req(int_req), .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_busy(mdu_busy), .mdu_result(mdu_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .stall(stall), .err(err)
  );
  always #5 clk = ~clk;
  assign mdu_busy   = stuck || (bcnt != 4'd0);
  assign mdu_result = (mdu_op == 4'd5) ? hi : (mdu_op == 4'd6) ? lo : 32'd0;
  always @(posedge clk) begin
    if (mdu_op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12}) bcnt <= 4'd5;
    else if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
    if (mdu_op == 4'd1) {hi, lo} <= $signed({{32{mdu_a[31]}}, mdu_a}) * $signed({{32{mdu_b[31]}}, mdu_b});
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [3:0] op, input logic [31:0] exp);
    req_valid = 1'b1; req_op = op; rsp_ready = 1'b1;
    #1 chk({tag, "_acc"}, req_ready, 1);
    tick(); req_valid = 1'b0;
    chk({tag, "_issue_valid"}, rsp_valid, 0);
    chk({tag, "_issue_op"}, mdu_op, op);
    tick();
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_data, exp);
    tick();
    chk({tag, "_done_valid"}, rsp_valid, 0);
    chk({tag, "_done_ready"}, req_ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    int_req = 1'b0; rsp_ready = 1'b1; stuck = 1'b0;
    tick(); tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mdu_op", mdu_op, 0);
    chk("rst_mdu_a", mdu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd3; req_b = 32'hFFFF_FFFE;
    #1 chk("mult_ready", req_ready, 1);
    chk("mult_stall", stall, 0);
    tick(); req_valid = 1'b0;
    chk("mult_issue_op", mdu_op, 1);
    chk("mult_issue_ready", req_ready, 0);
    chk("mult_a", mdu_a, 32'd3);
    chk("mult_b", mdu_b, 32'hFFFF_FFFE);
    tick();
    n = 0; nop = 0; nrsp = 0;
    while (!req_ready && n < 40) begin
      if (mdu_op != 4'd0) nop++;
      if (rsp_valid) nrsp++;
      n++;
      tick();
    end
    chk("mult_wait_cycles", n, 6);
    chk("mult_extra_op", nop, 0);
    chk("mult_no_rsp", nrsp, 0);
    rd("mflo", 4'd6, 32'hFFFF_FFFA);
    rd("mfhi", 4'd5, 32'hFFFF_FFFF);
    req_valid = 1'b1; req_op = 4'd5; rsp_ready = 1'b0;
    tick(); req_valid = 1'b0;
    tick();
    req_valid = 1'b1; req_op = 4'd6;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, 32'hFFFF_FFFF);
      chk("hold_stall", stall, 1);
      chk("hold_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("release_valid", rsp_valid, 1);
    chk("release_stall", stall, 1);
    tick();
    chk("release_done_valid", rsp_valid, 0);
    chk("release_done_stall", stall, 0);
    chk("release_done_ready", req_ready, 1);
    req_valid = 1'b0;
    req_valid = 1'b1; req_op = 4'd3; req_a = 32'd10; req_b = 32'd2;
    #1 chk("div_acc", req_ready, 1);
    tick(); req_valid = 1'b0; int_req = 1'b1;
    #1 chk("div_int_op", mdu_op, 0);
    tick(); int_req = 1'b0;
    #1 chk("div_idle_ready", req_ready, 1);
    chk("div_no_busy", mdu_busy, 0);
    chk("div_no_rsp", rsp_valid, 0);
    chk("div_idle_op", mdu_op, 0);
    req_valid = 1'b1; req_op = 4'd4; req_a = 32'd100; req_b = 32'd7;
    #1 tick(); req_valid = 1'b0;
    chk("divu_issue_op", mdu_op, 4);
    tick(); tick();
    chk("divu_wait_ready", req_ready, 0);
    chk("divu_wait_busy", mdu_busy, 1);
    #2 reset = 1'b1;
    #1 chk("divu_rst_a", mdu_a, 0);
    chk("divu_rst_b", mdu_b, 0);
    chk("divu_rst_op", mdu_op, 0);
    chk("divu_rst_valid", rsp_valid, 0);
    @(negedge clk) reset = 1'b0;
    tick();
    n = 0; nrsp = 0;
    while (n < 12) begin
      if (rsp_valid) nrsp++;
      n++;
      tick();
    end
    chk("divu_no_rsp", nrsp, 0);
    chk("divu_idle_ready", req_ready, 1);
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd5; req_b = 32'd6;
    #1 tick(); req_valid = 1'b0; stuck = 1'b1;
    tick();
    chk("wd_enter_state", dut.state_q, 2);
    repeat (15) tick();
    chk("wd_pre_err", err, 0);
    chk("wd_pre_state", dut.state_q, 2);
    tick();
`ifdef MDU_ISSUE_WATCHDOG_EN
    chk("wd_err", err, 1);
    chk("wd_state", dut.state_q, 0);
`else
    chk("wd_err", err, 0);
    chk("wd_state", dut.state_q, 2);
`endif
    stuck = 1'b0;
    tick();
    chk("wd_after_state", dut.state_q, 0);
`ifdef MDU_ISSUE_WATCHDOG_EN
    chk("wd_sticky", err, 1);
`else
    chk("wd_sticky", err, 0);
`endif
    reset = 1'b1;
    #1 chk("wd_rst_err", err, 0);
    reset = 1'b0;
    tick();
    chk("final_ready", req_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
